control_path: RTL and testbench
===============================

Name: control_path

Overview:
- Instruction-sequencing FSM and decoder of the processor core.
- Fetches a 32-bit instruction word, latches it and decodes it into datapath selects and strobes.
- Sequences load/store memory waits and traps on segmentation faults.
- Sits between the instruction/data memory interfaces and the ALU/register-file datapath.

Parameters:
- none (all field widths fixed by the ISA)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; forces HALT
go  in  1  start request, sampled only in HALT
instruction  in  32  instruction word from fetch memory
instr_segv  in  1  instruction fetch fault
data_segv  in  1  data access fault
wait_instr  in  1  fetch not ready
wait_data  in  1  data access not ready
pc_inc  out  1  advance program counter
opcode  out  3  IR[31:29]
form  out  1  IR[28]
alu_vec_perci  out  2  IR[27:26], vector/precision mode
alu_config  out  4  IR[25:22], ALU function
const_c  out  1  IR[21], C operand is immediate
a_select  out  4  IR[15:12]
alu_b_select  out  4  IR[11:8]
alu_c_select  out  4  IR[7:4]
alu_d_select  out  4  IR[3:0]
Y1_select  out  4  IR[15:12], first destination register
alu_Y2_select  out  4  IR[19:16], second destination register
reg_write  out  2  bit0 writes Y1, bit1 writes Y2
op_select  out  4  writeback source, one-hot: 0001 ALU, 0010 memory, 0100 immediate, 0000 none
mem_loca_addr  out  4  IR[11:8], address register for load/store
ld  out  1  load request
st  out  1  store request

Behaviour:
- Internal current_state is 5 bits: HALT=00000, READ_INS=01000, DO=01001, WAIT_LOAD=01010, WAIT_STORE=01100, TRAP=10000.
- Internal 32-bit IR.
- Reset: state=HALT, IR=0. All outputs are therefore 0.
- Field outputs are driven combinationally from IR in every state.
- Strobes (pc_inc, reg_write, op_select, ld, st) are 0 except where stated below.
- Opcode map:
  - 000 NOP
  - 001 LD
  - 010 ST
  - 011 HALT
  - 100 ALU dual-write
  - 101 ALU single-write
  - 110 reserved
  - 111 TRAP
- HALT: go=1 -> READ_INS, else stay.
- READ_INS, checked in priority order:
  - instr_segv=1 -> TRAP (priority over wait).
  - wait_instr=1 -> stay.
  - Otherwise: latch instruction into IR, pc_inc=1 for this cycle (combinational), -> DO.
- DO, one cycle; decodes the latched IR:
  - 100: reg_write=11, op_select=0001 (const_c=1 -> 0100). Next READ_INS.
  - 101: reg_write=01, op_select as for 100. Next READ_INS.
  - 001: ld=1. Next WAIT_LOAD.
  - 010: st=1. Next WAIT_STORE.
  - 011: next HALT.
  - 111: next TRAP.
  - 000 and 110: no strobes. Next READ_INS.
- WAIT_LOAD: ld held at 1.
  - data_segv=1 -> TRAP (no write).
  - wait_data=1 -> stay.
  - Otherwise: reg_write=01 and op_select=0010 this cycle, -> READ_INS.
- WAIT_STORE: st held at 1.
  - data_segv=1 -> TRAP.
  - wait_data=1 -> stay.
  - Otherwise -> READ_INS.
- TRAP: absorbing; no strobes; left only via reset.
- Reset has priority over every transition, including mid-wait.

Optional Feature:
- Macro CONTROL_PATH_ILLEGAL_TRAP_EN.
- Defined: opcode 110 in DO -> TRAP.
- Undefined: opcode 110 behaves as NOP.

Decomposition:
- Package control_path_pkg holds:
  - State encoding localparams.
  - Opcode constants.
  - op_select one-hot constants.
  - IR field bit-position constants.
- One natural sub-module: instr_decode, combinational IR -> field and select outputs. The FSM stays in control_path.

Test Plan:
- Reset for one cycle with go=0, wait_instr=1 -> state HALT, all strobes 0.
- go=1, wait_instr=1 -> READ_INS, held while wait_instr=1, pc_inc=0.
- Fetch ALU-dual instruction:
  - Stimulus: instruction=32'h80801234 in READ_INS, wait_instr drops to 0.
  - Next cycle: state DO, opcode=100, a_select=1, alu_b_select=2, alu_c_select=3, alu_d_select=4, reg_write=11, const_c=0, op_select=0001.
  - Following cycle: READ_INS.
- Load sequence:
  - Stimulus: LD instruction, wait_data=1 for 3 cycles.
  - Expected: DO -> WAIT_LOAD with ld=1 throughout; on wait_data=0, reg_write=01, op_select=0010, then READ_INS.
- Faults:
  - instr_segv=1 in READ_INS -> TRAP.
  - data_segv=1 in WAIT_STORE -> TRAP.
  - TRAP persists with go toggling; reset -> HALT.
- Opcode 011 -> HALT.
- Opcode 110 -> READ_INS without CONTROL_PATH_ILLEGAL_TRAP_EN, TRAP with it.

Source files
------------

// File: rtl/control_path_pkg.sv
// Shared constants for the control_path FSM and instruction decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package control_path_pkg;

  // FSM state encoding (legacy 5-bit codes)
  localparam logic [4:0] ST_HALT       = 5'b00000;
  localparam logic [4:0] ST_READ_INS   = 5'b01000;
  localparam logic [4:0] ST_DO         = 5'b01001;
  localparam logic [4:0] ST_WAIT_LOAD  = 5'b01010;
  localparam logic [4:0] ST_WAIT_STORE = 5'b01100;
  localparam logic [4:0] ST_TRAP       = 5'b10000;

  // Opcode map
  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_LD       = 3'b001;
  localparam logic [2:0] OP_ST       = 3'b010;
  localparam logic [2:0] OP_HALT     = 3'b011;
  localparam logic [2:0] OP_ALU_DUAL = 3'b100;
  localparam logic [2:0] OP_ALU_SNGL = 3'b101;
  localparam logic [2:0] OP_RSVD     = 3'b110;
  localparam logic [2:0] OP_TRAP     = 3'b111;

  // Writeback source select, one-hot
  localparam logic [3:0] OPSEL_NONE = 4'b0000;
  localparam logic [3:0] OPSEL_ALU  = 4'b0001;
  localparam logic [3:0] OPSEL_MEM  = 4'b0010;
  localparam logic [3:0] OPSEL_IMM  = 4'b0100;

  // IR field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int FORM_BIT   = 28;
  localparam int VEC_MSB    = 27;
  localparam int VEC_LSB    = 26;
  localparam int CFG_MSB    = 25;
  localparam int CFG_LSB    = 22;
  localparam int CONST_BIT  = 21;
  localparam int Y2_MSB     = 19;
  localparam int Y2_LSB     = 16;
  localparam int A_MSB      = 15;
  localparam int A_LSB      = 12;
  localparam int B_MSB      = 11;
  localparam int B_LSB      = 8;
  localparam int C_MSB      = 7;
  localparam int C_LSB      = 4;
  localparam int D_MSB      = 3;
  localparam int D_LSB      = 0;

endpackage

// File: rtl/control_path_instr_decode.sv
// Combinational slicing of the latched IR into datapath field selects.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs track IR continuously.
module control_path_instr_decode
  import control_path_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  opcode,
  output logic        form,
  output logic [1:0]  alu_vec_perci,
  output logic [3:0]  alu_config,
  output logic        const_c,
  output logic [3:0]  a_select,
  output logic [3:0]  alu_b_select,
  output logic [3:0]  alu_c_select,
  output logic [3:0]  alu_d_select,
  output logic [3:0]  Y1_select,
  output logic [3:0]  alu_Y2_select,
  output logic [3:0]  mem_loca_addr
);

  // IR[20] carries no field in the current ISA
  logic unused_ir_bit;
  assign unused_ir_bit = ir[20];

  assign opcode        = ir[OPCODE_MSB:OPCODE_LSB];
  assign form          = ir[FORM_BIT];
  assign alu_vec_perci = ir[VEC_MSB:VEC_LSB];
  assign alu_config    = ir[CFG_MSB:CFG_LSB];
  assign const_c       = ir[CONST_BIT];
  assign a_select      = ir[A_MSB:A_LSB];
  assign alu_b_select  = ir[B_MSB:B_LSB];
  assign alu_c_select  = ir[C_MSB:C_LSB];
  assign alu_d_select  = ir[D_MSB:D_LSB];
  // Y1 shares the A field: first destination is also the first source
  assign Y1_select     = ir[A_MSB:A_LSB];
  assign alu_Y2_select = ir[Y2_MSB:Y2_LSB];
  // Load/store address register shares the B field
  assign mem_loca_addr = ir[B_MSB:B_LSB];

endmodule

// File: rtl/control_path.sv
// Instruction-sequencing FSM: fetch, decode/execute, load/store waits, trap.
// Latency: fetch->DO 1 cycle; DO 1 cycle; memory waits last while wait_data holds.
// Backpressure: wait_instr/wait_data stall the FSM in place; CONTROL_PATH_ILLEGAL_TRAP_EN traps opcode 110.
module control_path
  import control_path_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] instruction,
  input  logic        instr_segv,
  input  logic        data_segv,
  input  logic        wait_instr,
  input  logic        wait_data,
  output logic        pc_inc,
  output logic [2:0]  opcode,
  output logic        form,
  output logic [1:0]  alu_vec_perci,
  output logic [3:0]  alu_config,
  output logic        const_c,
  output logic [3:0]  a_select,
  output logic [3:0]  alu_b_select,
  output logic [3:0]  alu_c_select,
  output logic [3:0]  alu_d_select,
  output logic [3:0]  Y1_select,
  output logic [3:0]  alu_Y2_select,
  output logic [1:0]  reg_write,
  output logic [3:0]  op_select,
  output logic [3:0]  mem_loca_addr,
  output logic        ld,
  output logic        st
);

  logic [4:0]  current_state;
  logic [4:0]  next_state;
  logic [31:0] ir;
  logic        ir_load;

  control_path_instr_decode u_decode (
    .ir            (ir),
    .opcode        (opcode),
    .form          (form),
    .alu_vec_perci (alu_vec_perci),
    .alu_config    (alu_config),
    .const_c       (const_c),
    .a_select      (a_select),
    .alu_b_select  (alu_b_select),
    .alu_c_select  (alu_c_select),
    .alu_d_select  (alu_d_select),
    .Y1_select     (Y1_select),
    .alu_Y2_select (alu_Y2_select),
    .mem_loca_addr (mem_loca_addr)
  );

  // Next-state and strobe generation; strobes default low in every state
  always_comb begin
    next_state = current_state;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    reg_write  = 2'b00;
    op_select  = OPSEL_NONE;
    ld         = 1'b0;
    st         = 1'b0;
    case (current_state)
      ST_HALT: begin
        if (go) next_state = ST_READ_INS;
      end
      ST_READ_INS: begin
        // a faulting fetch traps even if memory also reports not-ready
        if (instr_segv) begin
          next_state = ST_TRAP;
        end else if (!wait_instr) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = ST_DO;
        end
      end
      ST_DO: begin
        next_state = ST_READ_INS;
        case (opcode)
          OP_ALU_DUAL: begin
            reg_write = 2'b11;
            op_select = const_c ? OPSEL_IMM : OPSEL_ALU;
          end
          OP_ALU_SNGL: begin
            reg_write = 2'b01;
            op_select = const_c ? OPSEL_IMM : OPSEL_ALU;
          end
          OP_LD: begin
            ld         = 1'b1;
            next_state = ST_WAIT_LOAD;
          end
          OP_ST: begin
            st         = 1'b1;
            next_state = ST_WAIT_STORE;
          end
          OP_HALT: next_state = ST_HALT;
          OP_TRAP: next_state = ST_TRAP;
`ifdef CONTROL_PATH_ILLEGAL_TRAP_EN
          OP_RSVD: next_state = ST_TRAP;
`else
          OP_RSVD: next_state = ST_READ_INS;
`endif
          OP_NOP:  next_state = ST_READ_INS;
          default: next_state = ST_READ_INS;
        endcase
      end
      ST_WAIT_LOAD: begin
        ld = 1'b1;
        if (data_segv) begin
          next_state = ST_TRAP;
        end else if (!wait_data) begin
          reg_write  = 2'b01;
          op_select  = OPSEL_MEM;
          next_state = ST_READ_INS;
        end
      end
      ST_WAIT_STORE: begin
        st = 1'b1;
        if (data_segv) begin
          next_state = ST_TRAP;
        end else if (!wait_data) begin
          next_state = ST_READ_INS;
        end
      end
      ST_TRAP: next_state = ST_TRAP;
      // unreachable codes recover to HALT
      default: next_state = ST_HALT;
    endcase
  end

  // State and IR registers; reset overrides any pending transition
  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= ST_HALT;
      ir            <= 32'h0;
    end else begin
      current_state <= next_state;
      if (ir_load) ir <= instruction;
    end
  end

endmodule

// File: tb/tb_control_path.sv
module tb_control_path;
  import control_path_pkg::*;

  logic        clk = 1'b0;
  logic        reset, go, instr_segv, data_segv, wait_instr, wait_data;
  logic [31:0] instruction;
  logic        pc_inc, form, const_c, ld, st;
  logic [2:0]  opcode;
  logic [1:0]  alu_vec_perci, reg_write;
  logic [3:0]  alu_config, a_select, alu_b_select, alu_c_select, alu_d_select;
  logic [3:0]  Y1_select, alu_Y2_select, op_select, mem_loca_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_path dut (
    .clk(clk), .reset(reset), .go(go), .instruction(instruction),
    .instr_segv(instr_segv), .data_segv(data_segv),
    .wait_instr(wait_instr), .wait_data(wait_data),
    .pc_inc(pc_inc), .opcode(opcode), .form(form), .alu_vec_perci(alu_vec_perci),
    .alu_config(alu_config), .const_c(const_c), .a_select(a_select),
    .alu_b_select(alu_b_select), .alu_c_select(alu_c_select), .alu_d_select(alu_d_select),
    .Y1_select(Y1_select), .alu_Y2_select(alu_Y2_select), .reg_write(reg_write),
    .op_select(op_select), .mem_loca_addr(mem_loca_addr), .ld(ld), .st(st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // pack strobes {pc_inc, reg_write, op_select, ld, st} for compact checks
  function automatic logic [31:0] strobes();
    return {23'h0, pc_inc, reg_write, op_select, ld, st};
  endfunction

  task automatic fetch(input logic [31:0] word);
    instruction = word;
    wait_instr  = 1'b0;
    tick();
    wait_instr  = 1'b1;
    settle();
  endtask

  task automatic restart();
    reset = 1'b1; tick(); reset = 1'b0;
    go = 1'b1; tick(); go = 1'b0; settle();
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; instr_segv = 1'b0; data_segv = 1'b0;
    wait_instr = 1'b1; wait_data = 1'b0; instruction = 32'h0;

    // reset
    tick(); reset = 1'b0; settle();
    check("reset_state", dut.current_state, ST_HALT);
    check("reset_strobes", strobes(), 32'h0);
    check("reset_opcode", opcode, 3'b000);
    check("reset_fields", {a_select, alu_b_select, alu_c_select, alu_d_select}, 16'h0);

    // HALT -> READ_INS, held while wait_instr
    go = 1'b1; settle();
    check("halt_go_same_cycle", dut.current_state, ST_HALT);
    tick(); go = 1'b0; settle();
    check("read_ins_entry", dut.current_state, ST_READ_INS);
    check("read_wait_pcinc", pc_inc, 1'b0);
    tick(); settle();
    check("read_wait_hold", dut.current_state, ST_READ_INS);

    // ALU dual write
    instruction = 32'h80801234; wait_instr = 1'b0; settle();
    check("fetch_pc_inc", pc_inc, 1'b1);
    tick(); wait_instr = 1'b1; settle();
    check("alu2_state", dut.current_state, ST_DO);
    check("alu2_opcode", opcode, 3'b100);
    check("alu2_selects", {a_select, alu_b_select, alu_c_select, alu_d_select}, 16'h1234);
    check("alu2_config", alu_config, 4'h2);
    check("alu2_const", const_c, 1'b0);
    check("alu2_reg_write", reg_write, 2'b11);
    check("alu2_op_select", op_select, 4'b0001);
    check("alu2_pc_inc", pc_inc, 1'b0);
    tick(); settle();
    check("alu2_next", dut.current_state, ST_READ_INS);

    // ALU single write with immediate C
    fetch(32'hA0200000);
    check("alu1_state", dut.current_state, ST_DO);
    check("alu1_reg_write", reg_write, 2'b01);
    check("alu1_op_select", op_select, 4'b0100);
    tick(); settle();

    // Load with 3 wait cycles
    fetch(32'h20000500);
    wait_data = 1'b1; settle();
    check("ld_do_state", dut.current_state, ST_DO);
    check("ld_do_strobes", strobes(), {23'h0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0});
    check("ld_addr", mem_loca_addr, 4'h5);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("ld_wait_state", dut.current_state, ST_WAIT_LOAD);
      check("ld_wait_strobes", strobes(), {23'h0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0});
    end
    wait_data = 1'b0; settle();
    check("ld_done_strobes", strobes(), {23'h0, 1'b0, 2'b01, 4'b0010, 1'b1, 1'b0});
    tick(); settle();
    check("ld_done_next", dut.current_state, ST_READ_INS);
    check("ld_done_ld_low", ld, 1'b0);

    // Store completing after one wait cycle
    fetch(32'h40000000);
    check("st_do_st", st, 1'b1);
    wait_data = 1'b1; tick(); settle();
    check("st_wait_state", dut.current_state, ST_WAIT_STORE);
    wait_data = 1'b0; tick(); settle();
    check("st_done_next", dut.current_state, ST_READ_INS);

    // Reserved opcode 110
    fetch(32'hC0000000);
    check("rsvd_strobes", strobes(), 32'h0);
    tick(); settle();
`ifdef CONTROL_PATH_ILLEGAL_TRAP_EN
    check("rsvd_next", dut.current_state, ST_TRAP);
    restart();
`else
    check("rsvd_next", dut.current_state, ST_READ_INS);
`endif

    // HALT opcode, then restart via go
    fetch(32'h60000000);
    tick(); settle();
    check("halt_op_next", dut.current_state, ST_HALT);
    go = 1'b1; tick(); go = 1'b0; settle();
    check("halt_restart", dut.current_state, ST_READ_INS);

    // Fetch fault wins over wait_instr
    instr_segv = 1'b1; settle();
    check("isegv_pc_inc", pc_inc, 1'b0);
    tick(); instr_segv = 1'b0; settle();
    check("isegv_trap", dut.current_state, ST_TRAP);
    restart();

    // TRAP opcode
    fetch(32'hE0000000);
    tick(); settle();
    check("trap_op_next", dut.current_state, ST_TRAP);
    restart();

    // Reset during a load wait
    fetch(32'h20000300);
    wait_data = 1'b1; tick(); settle();
    check("ld_mid_state", dut.current_state, ST_WAIT_LOAD);
    reset = 1'b1; tick(); reset = 1'b0; wait_data = 1'b0; settle();
    check("reset_mid_wait", dut.current_state, ST_HALT);
    check("reset_mid_ir", opcode, 3'b000);
    go = 1'b1; tick(); go = 1'b0; settle();

    // Data fault in WAIT_STORE, TRAP absorbing with go toggling
    fetch(32'h40000000);
    wait_data = 1'b1; tick(); settle();
    check("st2_wait_state", dut.current_state, ST_WAIT_STORE);
    data_segv = 1'b1; settle();
    check("dsegv_no_write", reg_write, 2'b00);
    tick(); data_segv = 1'b0; wait_data = 1'b0; settle();
    check("dsegv_trap", dut.current_state, ST_TRAP);
    check("trap_strobes", strobes(), 32'h0);
    go = 1'b1; tick(); settle();
    check("trap_go_hi", dut.current_state, ST_TRAP);
    go = 1'b0; tick(); settle();
    check("trap_go_lo", dut.current_state, ST_TRAP);
    reset = 1'b1; tick(); reset = 1'b0; settle();
    check("trap_reset", dut.current_state, ST_HALT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
